// File: rtl/oscillator.sv
// Phase-accumulator oscillator: sawtooth, square, triangle and LFSR noise voices.
// Output is registered from the pre-update phase (one sample of latency).
module oscillator #(
  parameter int BITDEPTH    = 12,
  parameter int BITFRACTION = 12
) (
  input  logic                                sample_clock,
  input  logic                                rst,
  input  logic [BITDEPTH+BITFRACTION-4:0]     increment,
  input  logic [3:0]                          voice_select,
  output logic [BITDEPTH-1:0]                 out
);

  localparam int ACCW  = BITDEPTH + BITFRACTION;
  localparam int LFSRW = 23;
  localparam logic [LFSRW-1:0] LFSR_SEED = 23'h000001;

  logic [ACCW-1:0]     phase_q, phase_d;
  logic [LFSRW-1:0]    lfsr_q, lfsr_d;
  logic [BITDEPTH-1:0] out_q, out_d;
  logic [BITDEPTH-1:0] tri_field;
  logic                wrap;

  always_comb begin
    {wrap, phase_d} = {1'b0, phase_q} + {4'b0000, increment};

    // Noise advances once per phase wrap, independent of the selected voice.
    lfsr_d = lfsr_q;
    if (wrap) begin
      lfsr_d = {lfsr_q[LFSRW-2:0], lfsr_q[22] ^ lfsr_q[17]};
    end

    tri_field = phase_q[ACCW-2 -: BITDEPTH];

    out_d = {1'b1, {(BITDEPTH-1){1'b0}}};
    case (voice_select)
      4'd1:    out_d = phase_q[ACCW-1 -: BITDEPTH];
      4'd2:    out_d = {BITDEPTH{phase_q[ACCW-1]}};
      4'd3:    out_d = phase_q[ACCW-1] ? ~tri_field : tri_field;
      4'd4:    out_d = lfsr_q[LFSRW-1 -: BITDEPTH];
      default: out_d = {1'b1, {(BITDEPTH-1){1'b0}}};
    endcase
  end

  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      lfsr_q  <= LFSR_SEED;
      out_q   <= '0;
    end else begin
      phase_q <= phase_d;
      lfsr_q  <= lfsr_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_oscillator.sv
// Scoreboard bench for oscillator: a reference model predicts each sample at the
// clock edge, and the prediction is compared against out one time step later.
module tb_oscillator;

  logic        sample_clock = 1'b0;
  logic        rst          = 1'b1;
  logic [20:0] increment    = '0;
  logic [3:0]  voice_select = '0;
  logic [11:0] out;

  oscillator dut (
    .sample_clock (sample_clock),
    .rst          (rst),
    .increment    (increment),
    .voice_select (voice_select),
    .out          (out)
  );

  always #5 sample_clock = ~sample_clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic [23:0] m_phase = '0;
  logic [22:0] m_lfsr  = 23'h000001;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_wave(input logic [3:0] v, input logic [23:0] ph,
                                           input logic [22:0] lf);
    logic [11:0] fld;
    fld = ph[22:11];
    case (v)
      4'd1:    return ph[23:12];
      4'd2:    return ph[23] ? 12'hFFF : 12'h000;
      4'd3:    return ph[23] ? (12'hFFF - fld) : fld;
      4'd4:    return lf[22:11];
      default: return 12'h800;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = '0;
    m_lfsr  = 23'h000001;
    exp_q.delete();
  endtask

  // One sample: predict at the edge, compare just after it.
  task automatic run(input string tag, input int n);
    logic [24:0] sum;
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge sample_clock);
      exp_q.push_back(ref_wave(voice_select, m_phase, m_lfsr));
      sum = {1'b0, m_phase} + 25'(increment);
      m_phase = sum[23:0];
      if (sum[24]) m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: scoreboard empty", tag);
      end else begin
        e = exp_q.pop_front();
        chk(tag, out, e);
      end
    end
  endtask

  // Reset pulse placed between clock edges so it is checked as asynchronous.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    chk(tag, out, 12'h000);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_out", out, 12'h000);
    #2;
    rst = 1'b0;

    voice_select = 4'd1; increment = 21'd0;
    run("saw_inc0", 100);

    increment = 21'd16;
    run("saw_inc16", 1024);

    pulse_reset("rst_before_saw8192");
    voice_select = 4'd1; increment = 21'd8192;
    run("saw_inc8192", 2100);

    voice_select = 4'd2;
    run("square_8192", 2100);

    pulse_reset("rst_before_tri");
    voice_select = 4'd3;
    run("tri_8192", 2100);

    pulse_reset("rst_before_noise");
    voice_select = 4'd1; increment = 21'h100000;
    run("lfsr_bg_saw", 200);
    voice_select = 4'd4;
    run("noise", 2000);
    increment = 21'h1FFFFF;
    run("noise_maxinc", 500);

    increment = 21'd0;
    run("freeze_noise", 50);
    voice_select = 4'd3;
    run("freeze_tri", 50);

    for (int s = 0; s < 60; s++) begin
      voice_select = 4'($urandom_range(0, 15));
      increment    = 21'($urandom_range(0, 21'h1FFFFF));
      run("random_mix", 50);
    end

    voice_select = 4'd0; increment = 21'd8192;
    run("silence_v0", 200);
    voice_select = 4'd9;
    run("silence_v9", 200);
    pulse_reset("rst_midrun_async");
    run("after_midrun_rst", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
